// File: rtl/alu_operand_recover_pkg.sv
// Shared op-code and configuration-state definitions for the operand-recovery block.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;

    typedef enum logic {
        UNCFG,
        LOCKED
    } cfg_state_t;

endpackage

// File: rtl/alu_operand_recover_pipe_slice.sv
// One valid/ready register stage with a generic payload.
module alu_pipe_slice
    import alu_pkg::*;
#(
    parameter int PW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [PW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [PW-1:0] out_data
);

    // Stage can take a new word when empty or when its current word leaves this cycle.
    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data <= in_data;
            end
        end
    end

endmodule

// File: rtl/alu_operand_recover.sv
// Recovers ALU operand b from operand a and the ALU result, once the op code is locked.
module alu_operand_recover
    import alu_pkg::*;
#(
    parameter int W  = 16,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cfg_valid,
    input  logic [3:0]    cfg_op,
    output logic          cfg_ready,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_a,
    input  logic [W-1:0]  in_res,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_b,
    output logic          locked,
    output logic          mode_add,
    output logic          err_relock,
    output logic [CW-1:0] txn_count
);

    cfg_state_t state;

    logic           s1_in_valid;
    logic           s1_in_ready;
    logic           s1_valid;
    logic [W-1:0]   s1_a;
    logic [W-1:0]   s1_res;
    logic           s2_in_ready;
    logic [W-1:0]   b_calc;
    logic [W-1:0]   s2_a;
    logic [W-1:0]   s2_res;
    logic [W-1:0]   chk_sum;

    // One-shot configuration: the first offered op code wins, later offers only flag an error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= UNCFG;
            locked     <= 1'b0;
            mode_add   <= 1'b0;
            err_relock <= 1'b0;
        end else begin
            case (state)
                UNCFG: begin
                    if (cfg_valid) begin
                        state    <= LOCKED;
                        locked   <= 1'b1;
                        mode_add <= (cfg_op == OP_ADD);
                    end
                end
                LOCKED: begin
                    if (cfg_valid) begin
                        err_relock <= 1'b1;
                    end
                end
                default: begin
                    state <= UNCFG;
                end
            endcase
        end
    end

    assign cfg_ready   = (state == UNCFG);
    assign s1_in_valid = in_valid && locked;
    assign in_ready    = locked && s1_in_ready;

    alu_pipe_slice #(
        .PW(2 * W)
    ) u_s1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (s1_in_valid),
        .in_ready  (s1_in_ready),
        .in_data   ({in_a, in_res}),
        .out_valid (s1_valid),
        .out_ready (s2_in_ready),
        .out_data  ({s1_a, s1_res})
    );

    // Undo the ALU: add gave res = a + b, sub gave res = a - b.
    always_comb begin
        b_calc = '0;
        if (mode_add) begin
            b_calc = s1_res - s1_a;
        end else begin
            b_calc = s1_a - s1_res;
        end
    end

    alu_pipe_slice #(
        .PW(3 * W)
    ) u_s2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (s1_valid),
        .in_ready  (s2_in_ready),
        .in_data   ({b_calc, s1_a, s1_res}),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  ({out_b, s2_a, s2_res})
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txn_count <= '0;
        end else if (out_valid && out_ready && (txn_count != {CW{1'b1}})) begin
            txn_count <= txn_count + 1'b1;
        end
    end

    // In add mode the recovered b must re-add to the carried result.
    always_comb begin
        chk_sum = out_b + s2_a;
        if (locked && mode_add && out_valid) begin
            assert (chk_sum == s2_res);
        end
    end

endmodule

// File: tb/tb_alu_operand_recover.sv
// Self-checking bench: directed scenarios plus randomized streaming against a queue model.
module tb_alu_operand_recover;

    localparam int W  = 16;
    localparam int CW = 2;
    localparam int TXN_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cfg_valid = 1'b0;
    logic [3:0]    cfg_op = 4'd0;
    logic          cfg_ready;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_a = '0;
    logic [W-1:0]  in_res = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_b;
    logic          locked;
    logic          mode_add;
    logic          err_relock;
    logic [CW-1:0] txn_count;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_q[$];
    bit           exp_mode_add = 1'b0;
    int           exp_txn = 0;
    bit           stall_prev = 1'b0;
    logic [W-1:0] held_b = '0;

    alu_operand_recover #(
        .W  (W),
        .CW (CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_valid  (cfg_valid),
        .cfg_op     (cfg_op),
        .cfg_ready  (cfg_ready),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_res     (in_res),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_b      (out_b),
        .locked     (locked),
        .mode_add   (mode_add),
        .err_relock (err_relock),
        .txn_count  (txn_count)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] ref_b(input bit add, input logic [W-1:0] a, input logic [W-1:0] res);
        int unsigned diff;
        if (add) diff = (int'(res) - int'(a)) & ((1 << W) - 1);
        else     diff = (int'(a) - int'(res)) & ((1 << W) - 1);
        return diff[W-1:0];
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: handshakes decided at the next rising edge are observed on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            exp_txn = 0;
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                checkOutput("hold_valid", 32'(out_valid), 32'd1);
                checkOutput("hold_b", 32'(out_b), 32'(held_b));
            end
            if (in_valid && in_ready) exp_q.push_back(ref_b(exp_mode_add, in_a, in_res));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) checkOutput("spurious_out", 32'(exp_q.size()), 32'd1);
                else checkOutput("out_b", 32'(out_b), 32'(exp_q.pop_front()));
                if (exp_txn < TXN_MAX) exp_txn++;
            end
            stall_prev = out_valid && !out_ready;
            held_b = out_b;
        end
    end

    task automatic checkResetState();
        in_valid = 1'b1;
        #1;
        checkOutput("rst_cfg_ready", 32'(cfg_ready), 32'd1);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_b", 32'(out_b), 32'd0);
        checkOutput("rst_locked", 32'(locked), 32'd0);
        checkOutput("rst_mode_add", 32'(mode_add), 32'd0);
        checkOutput("rst_err", 32'(err_relock), 32'd0);
        checkOutput("rst_txn", 32'(txn_count), 32'd0);
        in_valid = 1'b0;
    endtask

    task automatic applyReset();
        rst_n = 1'b0;
        cfg_valid = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        checkResetState();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic configure(input logic [3:0] op);
        cfg_valid = 1'b1;
        cfg_op = op;
        in_valid = 1'b1;
        #1;
        checkOutput("cfg_cycle_in_ready", 32'(in_ready), 32'd0);
        checkOutput("cfg_cycle_cfg_ready", 32'(cfg_ready), 32'd1);
        tick();
        cfg_valid = 1'b0;
        in_valid = 1'b0;
        exp_mode_add = (op == 4'd0);
        #1;
        checkOutput("cfg_locked", 32'(locked), 32'd1);
        checkOutput("cfg_mode_add", 32'(mode_add), 32'(exp_mode_add));
        checkOutput("cfg_ready_after", 32'(cfg_ready), 32'd0);
    endtask

    // Offer one pair and hold it until accepted (bounded).
    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] res);
        int n;
        in_valid = 1'b1;
        in_a = a;
        in_res = res;
        #1;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            #1;
            n++;
        end
        if (!in_ready) checkOutput("in_timeout", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic randomPhase(input logic [3:0] op, input int cycles);
        int n;
        applyReset();
        configure(op);
        for (int i = 0; i < cycles; i++) begin
            in_valid = 1'($urandom);
            in_a = W'($urandom);
            in_res = W'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while ((out_valid || exp_q.size() != 0) && n < 10) begin
            tick();
            n++;
        end
        #1;
        checkOutput("rand_drained", 32'(exp_q.size()), 32'd0);
        checkOutput("rand_txn", 32'(txn_count), 32'(exp_txn));
    endtask

    initial begin
        int idx;
        bit fire;
        logic [W-1:0] hb;

        applyReset();

        // Add recover with latency check.
        configure(4'd0);
        out_ready = 1'b1;
        applyStimulus(16'h0003, 16'h0008);
        #1;
        checkOutput("t2_lat1_valid", 32'(out_valid), 32'd0);
        tick();
        #1;
        checkOutput("t2_lat2_valid", 32'(out_valid), 32'd1);
        checkOutput("t2_out_b", 32'(out_b), 32'h0005);
        tick();
        #1;
        checkOutput("t2_txn", 32'(txn_count), 32'd1);

        // Reset in the middle of a stream.
        applyStimulus(16'h1111, 16'h2222);
        applyReset();

        // Sub recover with wrap.
        configure(4'd7);
        out_ready = 1'b1;
        applyStimulus(16'h0001, 16'h0002);
        tick();
        #1;
        checkOutput("t3_valid", 32'(out_valid), 32'd1);
        checkOutput("t3_out_b", 32'(out_b), 32'hFFFF);
        checkOutput("t3_mode_add", 32'(mode_add), 32'd0);
        tick();

        // Back-pressure: only two pairs fit.
        applyReset();
        configure(4'd0);
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            in_valid = 1'b1;
            in_a = W'(idx + 1);
            in_res = W'(16'h0100 * (idx + 1) + idx + 1 + 5 * idx);
            #1;
            fire = in_ready;
            tick();
            if (fire) idx++;
        end
        #1;
        checkOutput("t4_accepted", 32'(idx), 32'd2);
        checkOutput("t4_in_ready", 32'(in_ready), 32'd0);
        checkOutput("t4_valid", 32'(out_valid), 32'd1);
        hb = out_b;
        tick();
        tick();
        #1;
        checkOutput("t4_held_b", 32'(out_b), 32'(hb));
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            in_valid = (idx < 4);
            in_a = W'(idx + 1);
            in_res = W'(16'h0100 * (idx + 1) + idx + 1 + 5 * idx);
            #1;
            checkOutput("t4_no_gap", 32'(out_valid), 32'd1);
            fire = in_valid && in_ready;
            tick();
            if (fire) idx++;
        end
        in_valid = 1'b0;
        #1;
        checkOutput("t4_all_in", 32'(idx), 32'd4);
        checkOutput("t4_empty", 32'(out_valid), 32'd0);

        // Relock attempt while in add mode.
        cfg_valid = 1'b1;
        cfg_op = 4'd1;
        tick();
        cfg_valid = 1'b0;
        #1;
        checkOutput("t5_err", 32'(err_relock), 32'd1);
        checkOutput("t5_mode_add", 32'(mode_add), 32'd1);
        checkOutput("t5_locked", 32'(locked), 32'd1);
        applyStimulus(16'd10, 16'd30);
        tick();
        #1;
        checkOutput("t5_out_b", 32'(out_b), 32'd20);
        tick();
        #1;
        checkOutput("t5_txn", 32'(txn_count), 32'(exp_txn));

        // Counter saturation.
        applyReset();
        configure(4'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(W'($urandom), W'($urandom));
        end
        for (int i = 0; i < 4; i++) tick();
        #1;
        checkOutput("t6_txn_sat", 32'(txn_count), 32'(TXN_MAX));
        tick();
        tick();
        #1;
        checkOutput("t6_txn_hold", 32'(txn_count), 32'(TXN_MAX));

        randomPhase(4'd0, 400);
        randomPhase(4'($urandom_range(1, 15)), 400);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
